// File: rtl/hamming_frame_decoder_if.sv
// Serial code-bit input, serial decoded-bit output and status bundle of the
// Hamming(7,4) frame decoder.
interface hamming_frame_decoder_if;
    logic        decoder_data_valid;
    logic        data_decoder_in;
    logic        data_decoder_out;
    logic        data_out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        frame_drop;
    logic [15:0] err_count;
    logic [7:0]  drop_count;

    modport master (
        output decoder_data_valid, data_decoder_in, out_ready,
        input  data_decoder_out, data_out_valid, frame_err, frame_drop,
               err_count, drop_count
    );

    modport slave (
        input  decoder_data_valid, data_decoder_in, out_ready,
        output data_decoder_out, data_out_valid, frame_err, frame_drop,
               err_count, drop_count
    );
endinterface

// File: rtl/hamming_frame_decoder.sv
// Collects a serial frame of Hamming(7,4) codewords, single-error corrects each
// codeword and streams the decoded data bits out MSB first with backpressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no decoded word pending; next completed frame is loaded
// S_SHIFT | decoded word streaming; a frame completing now is dropped
//         | unless it coincides with acceptance of the final bit
module hamming_frame_decoder #(
    parameter int N_CW       = 8,
    parameter int FRAME_BITS = 64
) (
    input  logic               clk_decoder_in,
    input  logic               rst,
    hamming_frame_decoder_if.slave dec
);
    localparam int OUT_BITS  = 4 * N_CW;
    localparam int IN_CNT_W  = $clog2(FRAME_BITS);
    localparam int OUT_CNT_W = $clog2(OUT_BITS);
    localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(FRAME_BITS - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_BITS - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  in_buf, in_buf_next;
    logic [IN_CNT_W-1:0]    in_cnt;
    logic [OUT_BITS-1:0]    out_word;
    logic [OUT_CNT_W-1:0]   out_cnt;
    logic [OUT_BITS-1:0]    dec_word;
    logic [4:0]             dec_errs;
    logic                   frame_done;
    logic                   accept;
    logic                   last_accept;
    logic                   load;
    logic                   drop;
    logic                   frame_err_q;
    logic                   frame_drop_q;
    logic [15:0]            err_count_q;
    logic [7:0]             drop_count_q;
    logic [16:0]            err_sum;

    // The decode sees the buffer including the bit arriving this cycle, so the
    // completing bit does not cost an extra cycle of latency.
    always_comb begin
        in_buf_next = in_buf;
        if (dec.decoder_data_valid) begin
            in_buf_next[IN_LAST - in_cnt] = dec.data_decoder_in;
        end
    end

    assign frame_done = dec.decoder_data_valid && (in_cnt == IN_LAST);

    always_comb begin
        logic [6:0] cw;
        logic [2:0] syn;
        cw       = '0;
        syn      = '0;
        dec_word = '0;
        dec_errs = '0;
        for (int k = 0; k < N_CW; k++) begin
            cw     = in_buf_next[7*k +: 7];
            syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
            syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
            syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
            // No double-error detection: every nonzero syndrome is a bit position.
            if (syn != 3'd0) begin
                cw[syn - 3'd1] = ~cw[syn - 3'd1];
                dec_errs       = dec_errs + 5'd1;
            end
            dec_word[4*k +: 4] = {cw[6], cw[5], cw[4], cw[2]};
        end
    end

    assign accept      = (state_q == S_SHIFT) && dec.out_ready;
    assign last_accept = accept && (out_cnt == OUT_LAST);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_done) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (frame_done && last_accept) begin
                    load = 1'b1;
                end else if (frame_done) begin
                    drop = 1'b1;
                end else if (last_accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_decoder_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign err_sum = {1'b0, err_count_q} + 17'(dec_errs);

    always_ff @(posedge clk_decoder_in or posedge rst) begin
        if (rst) begin
            in_buf       <= '0;
            in_cnt       <= '0;
            out_word     <= '0;
            out_cnt      <= '0;
            frame_err_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            err_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            in_buf       <= in_buf_next;
            frame_err_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            if (dec.decoder_data_valid) begin
                in_cnt <= frame_done ? '0 : in_cnt + IN_CNT_W'(1);
            end
            // Output word is a left shifter; the MSB is always the bit on offer.
            if (load) begin
                out_word    <= dec_word;
                out_cnt     <= '0;
                frame_err_q <= (dec_errs != 5'd0);
                err_count_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            end else if (accept) begin
                out_word <= out_word << 1;
                out_cnt  <= out_cnt + OUT_CNT_W'(1);
            end
            if (drop) begin
                frame_drop_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
        end
    end

    assign dec.data_out_valid   = (state_q == S_SHIFT);
    assign dec.data_decoder_out = (state_q == S_SHIFT) && out_word[OUT_BITS-1];
    assign dec.frame_err        = frame_err_q;
    assign dec.frame_drop       = frame_drop_q;
    assign dec.err_count        = err_count_q;
    assign dec.drop_count       = drop_count_q;
endmodule

// File: tb/tb_hamming_frame_decoder.sv
// Self-checking bench for hamming_frame_decoder: queue-based reference model
// compared every cycle, directed corner cases and randomized frames.
`timescale 1ns/1ps
module tb_hamming_frame_decoder;
    localparam int N_CW   = 8;
    localparam int FB     = 64;
    localparam int OB     = 32;
    localparam int S_N_CW = 4;
    localparam int S_FB   = 30;

    logic clk_decoder_in = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk_decoder_in = ~clk_decoder_in;

    hamming_frame_decoder_if bus ();
    hamming_frame_decoder_if sbus ();

    hamming_frame_decoder #(.N_CW(N_CW), .FRAME_BITS(FB)) dut (
        .clk_decoder_in(clk_decoder_in), .rst(rst), .dec(bus));
    hamming_frame_decoder #(.N_CW(S_N_CW), .FRAME_BITS(S_FB)) dut_s (
        .clk_decoder_in(clk_decoder_in), .rst(rst_s), .dec(sbus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Hamming(7,4) viewed as bit positions 1..7: the syndrome is the XOR of
    // the positions of all set bits.
    function automatic logic [6:0] encode_nib(input logic [3:0] d);
        logic [6:0] c;
        int s;
        c = '0;
        s = 0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
        return c;
    endfunction

    function automatic void decode_buf(input logic [127:0] b, input int n_cw,
                                       output logic [63:0] word, output int nerr);
        logic [6:0] c;
        int s;
        word = '0;
        nerr = 0;
        for (int k = 0; k < n_cw; k++) begin
            c = b[7*k +: 7];
            s = 0;
            for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
            if (s != 0) begin
                c[s-1] = ~c[s-1];
                nerr++;
            end
            word[4*k +: 4] = {c[6], c[5], c[4], c[2]};
        end
    endfunction

    function automatic logic [127:0] make_frame(input logic [63:0] data, input int n_cw, input int fb);
        logic [127:0] b;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 0; k < n_cw; k++) b[7*k +: 7] = encode_nib(data[4*k +: 4]);
        for (int i = fb; i < 128; i++) b[i] = 1'b0;
        return b;
    endfunction

    // Reference model: pending output bits are a queue, the frame is a plain array.
    logic         m_q[$];
    logic [127:0] m_buf = '0;
    int           m_in_cnt = 0;
    int           m_err_cnt = 0;
    int           m_drop_cnt = 0;
    int           m_loads = 0;
    logic         m_ferr = 1'b0;
    logic         m_fdrop = 1'b0;

    always @(posedge clk_decoder_in or posedge rst) begin
        logic [63:0] w;
        int ne;
        if (rst) begin
            m_q.delete();
            m_buf = '0; m_in_cnt = 0; m_err_cnt = 0; m_drop_cnt = 0;
            m_ferr = 1'b0; m_fdrop = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_fdrop = 1'b0;
            if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
            if (bus.decoder_data_valid) begin
                m_buf[FB-1-m_in_cnt] = bus.data_decoder_in;
                if (m_in_cnt == FB - 1) begin
                    m_in_cnt = 0;
                    if (m_q.size() == 0) begin
                        decode_buf(m_buf, N_CW, w, ne);
                        for (int i = OB - 1; i >= 0; i--) m_q.push_back(w[i]);
                        m_err_cnt = (m_err_cnt + ne > 65535) ? 65535 : m_err_cnt + ne;
                        m_ferr = (ne > 0);
                        m_loads++;
                    end else begin
                        m_fdrop = 1'b1;
                        if (m_drop_cnt < 255) m_drop_cnt++;
                    end
                end else begin
                    m_in_cnt++;
                end
            end
        end
    end

    logic [63:0] cap = '0;
    int cap_n = 0, n_ferr = 0, n_fdrop = 0, n_vrise = 0;
    logic prev_valid = 1'b0;
    logic [63:0] s_cap = '0;
    int s_cap_n = 0;

    always @(negedge clk_decoder_in) begin
        check("valid", bus.data_out_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("data", bus.data_decoder_out, m_q[0]);
        check("frame_err", bus.frame_err, m_ferr);
        check("frame_drop", bus.frame_drop, m_fdrop);
        check("err_count", bus.err_count, m_err_cnt);
        check("drop_count", bus.drop_count, m_drop_cnt);
        if (rst) check("rst_data", bus.data_decoder_out, 0);
        if (bus.data_out_valid && bus.out_ready) begin
            cap = {cap[62:0], bus.data_decoder_out};
            cap_n++;
        end
        if (bus.frame_err) n_ferr++;
        if (bus.frame_drop) n_fdrop++;
        if (bus.data_out_valid && !prev_valid) n_vrise++;
        prev_valid = bus.data_out_valid;
        if (sbus.data_out_valid && sbus.out_ready) begin
            s_cap = {s_cap[62:0], sbus.data_decoder_out};
            s_cap_n++;
        end
    end

    task automatic cyc();
        @(posedge clk_decoder_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic d, input logic r);
        bus.decoder_data_valid = v;
        bus.data_decoder_in    = d;
        bus.out_ready          = r;
        cyc();
    endtask

    task automatic s_drive(input logic v, input logic d, input logic r);
        sbus.decoder_data_valid = v;
        sbus.data_decoder_in    = d;
        sbus.out_ready          = r;
        cyc();
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return logic'($urandom_range(0, 1));
    endfunction

    // mode: 0 = out_ready low, 1 = out_ready high, 2 = random
    task automatic send_frame(input logic [127:0] f, input bit gaps, input int mode);
        for (int j = 0; j < FB; j++) begin
            while (gaps && $urandom_range(0, 3) == 0)
                drive(1'b0, logic'($urandom_range(0, 1)), pick_ready(mode));
            drive(1'b1, f[FB-1-j], pick_ready(mode));
        end
        bus.decoder_data_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((m_q.size() > 0 || bus.data_out_valid) && n < max_cyc) begin
            drive(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("drain_bound", (m_q.size() > 0 || bus.data_out_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] f_clean, f_err, fa, fb_, sf;
        logic [63:0] w, da, db, ds;
        int ne, cap0, ferr0, fdrop0, vrise0, loads0, scap0, n;

        bus.decoder_data_valid = 1'b0; bus.data_decoder_in = 1'b0; bus.out_ready = 1'b1;
        sbus.decoder_data_valid = 1'b0; sbus.data_decoder_in = 1'b0; sbus.out_ready = 1'b1;

        f_clean = '0;
        for (int k = 0; k < N_CW; k++) f_clean[7*k +: 7] = 7'b1010101;
        f_err = f_clean;
        f_err[6:0] = 7'b1000101;
        decode_buf(f_clean, N_CW, w, ne);
        check("pin_clean_word", w[31:0], 32'hBBBB_BBBB);
        check("pin_clean_nerr", ne, 0);
        decode_buf(f_err, N_CW, w, ne);
        check("pin_err_word", w[31:0], 32'hBBBB_BBBB);
        check("pin_err_nerr", ne, 1);
        check("pin_encode", encode_nib(4'hB), 7'b1010101);

        repeat (3) cyc();
        check("rst_valid", bus.data_out_valid, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_drop_count", bus.drop_count, 0);
        rst = 1'b0; rst_s = 1'b0;
        cyc();

        // all-zero frame
        cap0 = cap_n; vrise0 = n_vrise;
        send_frame('0, 1'b0, 1);
        drain(100);
        check("zero_bits", cap_n - cap0, 32);
        check("zero_word", cap[31:0], 0);
        check("zero_vrise", n_vrise - vrise0, 1);
        check("zero_err_count", bus.err_count, 0);

        // clean 1010101 codewords
        cap0 = cap_n; ferr0 = n_ferr;
        send_frame(f_clean, 1'b0, 1);
        drain(100);
        check("clean_word", cap[31:0], 32'hBBBB_BBBB);
        check("clean_ferr", n_ferr - ferr0, 0);

        // single corrected error in codeword 0
        ferr0 = n_ferr;
        send_frame(f_err, 1'b0, 1);
        drain(100);
        check("corr_word", cap[31:0], 32'hBBBB_BBBB);
        check("corr_ferr", n_ferr - ferr0, 1);
        check("corr_err_count", bus.err_count, 1);

        // two frames under full backpressure: second is dropped
        cap0 = cap_n; fdrop0 = n_fdrop;
        send_frame(f_clean, 1'b0, 0);
        send_frame(f_err, 1'b0, 0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("hold_valid", bus.data_out_valid, 1);
        check("hold_bit31", bus.data_decoder_out, 1);
        check("hold_none_taken", cap_n - cap0, 0);
        check("drop_pulses", n_fdrop - fdrop0, 1);
        check("drop_count", bus.drop_count, 1);
        check("drop_err_count", bus.err_count, 1);
        drain(100);
        check("drop_word", cap[31:0], 32'hBBBB_BBBB);

        // next frame completes on the final accepted bit
        da = {32'h0, $urandom()};
        db = {32'h0, $urandom()};
        fa = make_frame(da, N_CW, FB);
        fb_ = make_frame(db, N_CW, FB);
        fb_[7*3 + 2] = ~fb_[7*3 + 2];
        fdrop0 = n_fdrop; vrise0 = n_vrise; cap0 = cap_n;
        send_frame(fa, 1'b0, 1);
        for (int j = 0; j < FB; j++) drive(1'b1, fb_[FB-1-j], logic'(j >= 32));
        bus.decoder_data_valid = 1'b0;
        drain(100);
        check("b2b_no_drop", n_fdrop - fdrop0, 0);
        check("b2b_vrise", n_vrise - vrise0, 1);
        check("b2b_bits", cap_n - cap0, 64);
        check("b2b_words", cap, {da[31:0], db[31:0]});

        // randomized frames, gaps and backpressure
        loads0 = m_loads; cap0 = cap_n;
        for (int t = 0; t < 30; t++) begin
            logic [127:0] f;
            da = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                f = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                f = make_frame(da, N_CW, FB);
                for (int k = 0; k < N_CW; k++)
                    if ($urandom_range(0, 2) == 0) f[7*k + $urandom_range(0, 6)] ^= 1'b1;
            end
            send_frame(f, 1'b1, 2);
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) drive(1'b0, 1'b0, pick_ready(2));
        end
        drain(200);
        check("rand_bits", cap_n - cap0, 32 * (m_loads - loads0));

        // reset mid-frame and mid-shift
        send_frame(f_err, 1'b0, 0);
        for (int j = 0; j < 20; j++) drive(1'b1, logic'($urandom_range(0, 1)), 1'b0);
        rst = 1'b1;
        bus.decoder_data_valid = 1'b0;
        #2;
        check("mid_rst_valid", bus.data_out_valid, 0);
        check("mid_rst_err_count", bus.err_count, 0);
        check("mid_rst_drop_count", bus.drop_count, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        cap0 = cap_n;
        send_frame(f_clean, 1'b0, 1);
        drain(100);
        check("post_rst_bits", cap_n - cap0, 32);
        check("post_rst_word", cap[31:0], 32'hBBBB_BBBB);

        // small configuration: 4 codewords in 30-bit frames
        for (int j = 0; j < 10; j++) s_drive(1'b1, logic'($urandom_range(0, 1)), 1'b1);
        rst_s = 1'b1;
        sbus.decoder_data_valid = 1'b0;
        #2;
        check("s_rst_valid", sbus.data_out_valid, 0);
        check("s_rst_data", sbus.data_decoder_out, 0);
        check("s_rst_ferr", sbus.frame_err, 0);
        check("s_rst_fdrop", sbus.frame_drop, 0);
        check("s_rst_err_count", sbus.err_count, 0);
        check("s_rst_drop_count", sbus.drop_count, 0);
        cyc();
        rst_s = 1'b0;
        cyc();
        ds = {48'h0, 16'($urandom())};
        sf = make_frame(ds, S_N_CW, S_FB);
        sf[7*2 + 5] = ~sf[7*2 + 5];
        decode_buf(sf, S_N_CW, w, ne);
        check("s_model_word", w[15:0], ds[15:0]);
        scap0 = s_cap_n;
        for (int j = 0; j < S_FB; j++) s_drive(1'b1, sf[S_FB-1-j], 1'b1);
        sbus.decoder_data_valid = 1'b0;
        n = 0;
        while (s_cap_n - scap0 < 16 && n < 100) begin
            s_drive(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("s_bits", s_cap_n - scap0, 16);
        check("s_word", s_cap[15:0], ds[15:0]);
        check("s_err_count", sbus.err_count, 1);
        check("s_drop_count", sbus.drop_count, 0);
        repeat (2) s_drive(1'b0, 1'b0, 1'b1);
        check("s_idle_valid", sbus.data_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hamming_frame_decoder.md
HAMMING_FRAME_DECODER -- requirements
Module: hamming_frame_decoder

Interface
REQ-001 SHALL have parameter N_CW, default 8: Hamming(7,4) codewords per frame, range 1..16.
REQ-002 SHALL have parameter FRAME_BITS, default 64: serial bits per frame; FRAME_BITS >= 7*N_CW and FRAME_BITS <= 128.
REQ-003 SHALL have port clk_decoder_in, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port decoder_data_valid, input, 1: data_decoder_in is sampled this cycle.
REQ-006 SHALL have port data_decoder_in, input, 1: serial code bit.
REQ-007 SHALL have port data_decoder_out, output, 1: serial decoded bit.
REQ-008 SHALL have port data_out_valid, output, 1: data_decoder_out is valid.
REQ-009 SHALL have port out_ready, input, 1: sink accepts the output bit this cycle.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse when a loaded frame had at least one nonzero syndrome.
REQ-011 SHALL have port frame_drop, output, 1: one-cycle pulse when a completed frame is discarded.
REQ-012 SHALL have port err_count, output, 16: saturating count of corrected codewords.
REQ-013 SHALL have port drop_count, output, 8: saturating count of dropped frames.

Function
REQ-014 SHALL write each bit sampled with decoder_data_valid=1 into input buffer index FRAME_BITS-1-in_cnt, then increment in_cnt; the first bit of a frame lands at the MSB.
REQ-015 SHALL treat codeword k (k=0..N_CW-1) as buffer bits [7k+6:7k], and SHALL ignore buffer bits at or above 7*N_CW.
REQ-016 SHALL compute syndrome s = {s4,s2,s1} per codeword c[6:0]:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
REQ-017 SHALL, when s != 0, invert bit c[s-1] before data extraction; data nibble k = {c6,c5,c4,c2} is placed at decoded word bits [4k+3:4k].
REQ-018 SHALL, on the cycle in_cnt = FRAME_BITS-1 with decoder_data_valid=1, wrap in_cnt to 0 and mark the frame complete; the decode uses the buffer including the bit written that cycle.
REQ-019 SHALL implement output FSM IDLE/SHIFT:
  - complete in IDLE: load decoded word, out_cnt=0, go to SHIFT.
  - complete in SHIFT: drop the frame.
REQ-020 SHALL, in SHIFT, hold data_out_valid=1 and drive decoded bit 4*N_CW-1-out_cnt.
REQ-021 SHALL advance out_cnt only when data_out_valid and out_ready are both 1; while out_ready=0, data_decoder_out SHALL hold its value.
REQ-022 SHALL, on acceptance of bit out_cnt = 4*N_CW-1, return to IDLE.
REQ-023 SHALL treat a frame completing in the same cycle as the final accepted output bit as a load: no drop, SHIFT continues with out_cnt=0.
REQ-024 SHALL give a latency of 1 cycle: data_out_valid rises on the edge after the completing bit is sampled.
REQ-025 SHALL, on a drop, pulse frame_drop and increment drop_count (saturating at 255); the input side SHALL never stall.
REQ-026 SHALL, on a load, add the number of nonzero-syndrome codewords to err_count (saturating at 65535), and pulse frame_err if that number is greater than 0.
REQ-027 SHALL provide no double-error detection: any nonzero syndrome is corrected as a single error.

Reset
REQ-028 SHALL, while rst=1, clear in_cnt, out_cnt, both buffers, err_count and drop_count, and force state IDLE.
REQ-029 SHALL, while rst=1, drive data_decoder_out=0, data_out_valid=0, frame_err=0 and frame_drop=0.
REQ-030 SHALL discard any partial input frame or partial output shift when reset is asserted mid-operation; after release, the next valid bit is the first bit of a new frame.

Verification
REQ-031 SHALL cover: defaults, 64 bits all zero, out_ready=1 -> 32 zeros with data_out_valid high for 32 consecutive cycles starting 1 cycle after the last input bit; err_count=0.
REQ-032 SHALL cover: all 8 codewords 7'b1010101 -> output 32'hBBBB_BBBB; frame_err not pulsed.
REQ-033 SHALL cover: codeword 0 = 7'b1000101 (c4 flipped), others 7'b1010101 -> output 32'hBBBB_BBBB; frame_err pulses once; err_count=1.
REQ-034 SHALL cover: out_ready=0 throughout while two frames arrive back to back -> first frame held at bit 31; frame_drop pulses once; drop_count=1; err_count unchanged by the dropped frame.
REQ-035 SHALL cover: second frame completing in the same cycle as the final accepted output bit -> no frame_drop; data_out_valid stays high; the second word streams immediately.
REQ-036 SHALL cover: N_CW=4, FRAME_BITS=30, rst asserted after 10 input bits -> outputs zero; a following full frame decodes to 16 correct bits.
